// File: rtl/blue_sequencer.sv
// Operand sequencer and 8x16 register file feeding the blue ALU.
// Reads two operands, registers them toward the ALU, then writes results and flags back.
module blue_sequencer #(
  parameter int REGS   = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [15:0]       cmd_op,
  input  logic [ADDR_W-1:0] cmd_ra,
  input  logic [ADDR_W-1:0] cmd_rb,
  input  logic [1:0]        cmd_wb,
  output logic [15:0]       alu_opCode,
  output logic [15:0]       alu_A,
  output logic [15:0]       alu_B,
  output logic [2:0]        alu_ZNC,
  input  logic [15:0]       alu_A_res,
  input  logic [15:0]       alu_B_res,
  input  logic [2:0]        alu_ZNC_res,
  output logic [2:0]        flags,
  output logic              done,
  output logic              busy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [15:0]       ld_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data
);

  // state  | meaning
  // IDLE   | ready for a command; host load port active
  // READ   | operands and flags registered onto alu_*
  // EXEC   | ALU settles; results and flags written back at the closing edge
  // DONE   | one-cycle done pulse
  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [15:0]       regs [REGS];
  logic [15:0]       op_q;
  logic [ADDR_W-1:0] ra_q;
  logic [ADDR_W-1:0] rb_q;
  logic [1:0]        wb_q;
  logic              accept;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        busy      = 1'b0;
        cmd_ready = !rst;
        accept    = cmd_valid && !rst;
        if (accept) state_nxt = S_READ;
      end
      S_READ:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_DONE;
      S_DONE: begin
        done      = !rst;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Load and write-back live in different states, so they never contend.
  // Within EXEC the rb write is last, letting the B result win a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
      flags      <= '0;
      alu_opCode <= '0;
      alu_A      <= '0;
      alu_B      <= '0;
      alu_ZNC    <= '0;
      op_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      wb_q       <= '0;
    end else begin
      if (state == S_IDLE && ld_en) regs[ld_addr] <= ld_data;
      if (accept) begin
        op_q <= cmd_op;
        ra_q <= cmd_ra;
        rb_q <= cmd_rb;
        wb_q <= cmd_wb;
      end
      if (state == S_READ) begin
        alu_opCode <= op_q;
        alu_A      <= regs[ra_q];
        alu_B      <= regs[rb_q];
        alu_ZNC    <= flags;
      end
      if (state == S_EXEC) begin
        if (wb_q[1]) regs[ra_q] <= alu_A_res;
        if (wb_q[0]) regs[rb_q] <= alu_B_res;
        flags <= alu_ZNC_res;
      end
    end
  end

  assign rd_data = regs[rd_addr];

endmodule

// File: tb/tb_blue_sequencer.sv
// Directed bench for blue_sequencer with a small behavioural ALU model.
module tb_blue_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_op;
  logic [2:0]  cmd_ra;
  logic [2:0]  cmd_rb;
  logic [1:0]  cmd_wb;
  logic [15:0] alu_opCode;
  logic [15:0] alu_A;
  logic [15:0] alu_B;
  logic [2:0]  alu_ZNC;
  logic [15:0] alu_A_res;
  logic [15:0] alu_B_res;
  logic [2:0]  alu_ZNC_res;
  logic [2:0]  flags;
  logic        done;
  logic        busy;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;

  logic        use_add;
  logic [15:0] a_const;
  logic [15:0] b_const;
  logic [2:0]  znc_set;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  blue_sequencer #(.REGS(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_wb(cmd_wb),
    .alu_opCode(alu_opCode), .alu_A(alu_A), .alu_B(alu_B), .alu_ZNC(alu_ZNC),
    .alu_A_res(alu_A_res), .alu_B_res(alu_B_res), .alu_ZNC_res(alu_ZNC_res),
    .flags(flags), .done(done), .busy(busy),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // ALU stand-in: either A+B / B, or fixed constants
  always_comb begin
    if (use_add) begin
      alu_A_res = alu_A + alu_B;
      alu_B_res = alu_B;
    end else begin
      alu_A_res = a_const;
      alu_B_res = b_const;
    end
    alu_ZNC_res = znc_set;
  end

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [2:0] a, input logic [15:0] exp_v);
    rd_addr = a;
    #1;
    check_val(tag, rd_data, exp_v);
  endtask

  task automatic start_cmd(input logic [15:0] op, input logic [2:0] ra, input logic [2:0] rb,
                           input logic [1:0] wb);
    cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_wb = wb;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Bounded wait for done; ends back in IDLE
  task automatic wait_done();
    for (int i = 0; i < 8; i++) begin
      if (done) break;
      tick();
    end
    check_val("done_seen", {15'd0, done}, 16'd1);
    tick();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_wb = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    use_add = 1'b1; a_const = '0; b_const = '0; znc_set = '0;

    // reset
    tick();
    check_val("ready_in_rst", {15'd0, cmd_ready}, 16'd0);
    tick();
    rst = 1'b0;
    #1;
    check_val("ready_after_rst", {15'd0, cmd_ready}, 16'd1);
    check_val("busy_after_rst", {15'd0, busy}, 16'd0);
    check_val("done_after_rst", {15'd0, done}, 16'd0);
    check_val("flags_after_rst", {13'd0, flags}, 16'd0);
    check_val("aluA_after_rst", alu_A, 16'd0);
    for (int i = 0; i < 8; i++) read_chk("reg_rst", 3'(i), 16'h0000);

    // host load
    load(3'd3, 16'h1234);
    read_chk("load_reg3", 3'd3, 16'h1234);

    // basic op: reg1 = 5 + 7
    load(3'd1, 16'h0005);
    load(3'd2, 16'h0007);
    start_cmd(16'h0001, 3'd1, 3'd2, 2'b10);
    check_val("busy_read", {15'd0, busy}, 16'd1);
    check_val("ready_read", {15'd0, cmd_ready}, 16'd0);
    tick();
    check_val("basic_aluA", alu_A, 16'h0005);
    check_val("basic_aluB", alu_B, 16'h0007);
    check_val("basic_op", alu_opCode, 16'h0001);
    check_val("basic_znc", {13'd0, alu_ZNC}, 16'd0);
    check_val("done_exec", {15'd0, done}, 16'd0);
    read_chk("reg1_before_wb", 3'd1, 16'h0005);
    tick();
    read_chk("reg1_after_wb", 3'd1, 16'h000C);
    read_chk("reg2_kept", 3'd2, 16'h0007);
    check_val("done_pulse", {15'd0, done}, 16'd1);
    check_val("ready_done", {15'd0, cmd_ready}, 16'd0);
    tick();
    check_val("done_cleared", {15'd0, done}, 16'd0);
    check_val("ready_again", {15'd0, cmd_ready}, 16'd1);

    // collision: B result wins
    use_add = 1'b0; a_const = 16'hAAAA; b_const = 16'h5555; znc_set = 3'b000;
    start_cmd(16'h0002, 3'd4, 3'd4, 2'b11);
    wait_done();
    read_chk("collision_reg4", 3'd4, 16'h5555);

    // flag chaining, wb=00 leaves registers alone
    znc_set = 3'b001;
    start_cmd(16'h0003, 3'd1, 3'd2, 2'b00);
    wait_done();
    check_val("flags_chain1", {13'd0, flags}, 16'h0001);
    read_chk("wb00_reg1", 3'd1, 16'h000C);
    read_chk("wb00_reg2", 3'd2, 16'h0007);
    znc_set = 3'b010;
    start_cmd(16'h0004, 3'd1, 3'd2, 2'b00);
    tick();
    check_val("chain_aluZNC", {13'd0, alu_ZNC}, 16'h0001);
    tick();
    check_val("flags_chain2", {13'd0, flags}, 16'h0002);
    tick();

    // held cmd_valid, ignored op change, load during EXEC
    znc_set = 3'b000;
    cmd_valid = 1'b1; cmd_op = 16'h0033; cmd_ra = 3'd1; cmd_rb = 3'd2; cmd_wb = 2'b00;
    tick();
    cmd_op = 16'h00EE;
    tick();
    check_val("held_op_first", alu_opCode, 16'h0033);
    check_val("held_ready_exec", {15'd0, cmd_ready}, 16'd0);
    ld_en = 1'b1; ld_addr = 3'd5; ld_data = 16'hBEEF;
    tick();
    ld_en = 1'b0;
    read_chk("ld_in_exec_dropped", 3'd5, 16'h0000);
    check_val("held_ready_done", {15'd0, cmd_ready}, 16'd0);
    tick();
    check_val("held_ready_idle", {15'd0, cmd_ready}, 16'd1);
    tick();
    cmd_valid = 1'b0;
    check_val("held_second_accept", {15'd0, busy}, 16'd1);
    tick();
    check_val("held_op_second", alu_opCode, 16'h00EE);
    wait_done();

    // load and accept in the same cycle
    ld_en = 1'b1; ld_addr = 3'd6; ld_data = 16'h00FF;
    start_cmd(16'h0005, 3'd6, 3'd0, 2'b00);
    ld_en = 1'b0;
    tick();
    check_val("ld_accept_aluA", alu_A, 16'h00FF);
    wait_done();

    // reset during EXEC aborts write-back
    use_add = 1'b1; znc_set = 3'b111;
    start_cmd(16'h0006, 3'd1, 3'd2, 2'b11);
    tick();
    rst = 1'b1;
    tick();
    check_val("rst_done", {15'd0, done}, 16'd0);
    check_val("rst_flags", {13'd0, flags}, 16'd0);
    read_chk("rst_reg1", 3'd1, 16'h0000);
    read_chk("rst_reg2", 3'd2, 16'h0000);
    rst = 1'b0;
    #1;
    check_val("rst_idle_busy", {15'd0, busy}, 16'd0);
    check_val("rst_idle_ready", {15'd0, cmd_ready}, 16'd1);
    tick();
    check_val("rst_no_done", {15'd0, done}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/blue_sequencer.md
# blue_sequencer

Operand sequencer and register file placed directly upstream of the blue ALU circuit. It accepts one command at a time over a valid/ready handshake, reads two operands from an 8×16 register file, and drives the ALU's opcode, A, B and ZNC inputs from registers. It then captures the ALU's A/B results and ZNC flags, writing them back into the register file and the flags register. A load/read side port lets the host initialise and inspect registers.

## Interface
- REGS, 8: number of 16-bit registers; must be a power of two.
- ADDR_W, 3: register address width (log2 REGS).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE.
- cmd_op  in  16  opcode passed to the ALU.
- cmd_ra  in  ADDR_W  A operand source and A result destination.
- cmd_rb  in  ADDR_W  B operand source and B result destination.
- cmd_wb  in  2  write enables: bit1 writes A result to ra, bit0 writes B result to rb.
- alu_opCode  out  16  registered opcode to the ALU.
- alu_A  out  16  registered A operand.
- alu_B  out  16  registered B operand.
- alu_ZNC  out  3  registered flags-in (Z,N,C at bits 2,1,0).
- alu_A_res  in  16  ALU A result.
- alu_B_res  in  16  ALU B result.
- alu_ZNC_res  in  3  ALU flags result.
- flags  out  3  current ZNC flags register.
- done  out  1  one-cycle pulse after write-back.
- busy  out  1  high in any state except IDLE.
- ld_en  in  1  host register write.
- ld_addr  in  ADDR_W  host write address.
- ld_data  in  16  host write data.
- rd_addr  in  ADDR_W  host read address.
- rd_data  out  16  combinational read of regfile[rd_addr].

## Operation
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- States: IDLE → READ → EXEC → DONE → IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch cmd_op/ra/rb/wb and go to READ.
- READ:
  - alu_opCode<=op, alu_A<=reg[ra], alu_B<=reg[rb], alu_ZNC<=flags.
  - Go to EXEC.
- EXEC:
  - ALU outputs settle combinationally.
  - At the closing edge: if wb[1], reg[ra]<=alu_A_res; if wb[0], reg[rb]<=alu_B_res.
  - flags<=alu_ZNC_res, always, regardless of wb.
  - Go to DONE.
- DONE: done=1 for one cycle; go to IDLE.
- Write-back collision: ra==rb with wb=2'b11 means the B result wins.
- Host load port:
  - ld_en is honoured only in IDLE; ld_en outside IDLE is dropped silently.
  - ld_en together with a command accept in the same cycle: the load commits first, and READ sees the loaded value.
- cmd_op and operand inputs are ignored outside the accepting edge.
- flags feeds alu_ZNC for the next command, so carry chains across commands.

## Timing
- Reset values:
  - state=IDLE.
  - All registers = 0x0000.
  - flags=3'b000.
  - alu_opCode, alu_A, alu_B = 0; alu_ZNC=0.
  - done=0, busy=0.
  - cmd_ready=0 while rst is high, 1 in the first cycle after.
- Command sequence, with the accept at edge N:
  - Operands visible on alu_* after edge N+1.
  - Regfile and flags updated at edge N+2.
  - done high during cycle N+2→N+3.
  - cmd_ready high again after edge N+3.
- Throughput: one command per 4 cycles. A back-to-back command reads the previous command's write-back.
- rd_data reflects regfile writes immediately after the writing edge.
- rst asserted in any state:
  - The next state is IDLE.
  - Pending write-back is aborted with no regfile or flag update.
  - done stays 0.
- alu_* outputs hold their values from READ until the next READ.

## Test plan
- Reset and load: after reset, rd_data=0 for all addresses and cmd_ready=1. Load reg3=0x1234, then rd_addr=3 → rd_data=0x1234 the next cycle.
- Basic op:
  - Setup: reg1=0x0005, reg2=0x0007, bench ALU model returns A_res=A+B, B_res=B, ZNC=000.
  - Stimulus: cmd op=0x0001, ra=1, rb=2, wb=10.
  - Required response: alu_A=5 and alu_B=7 after N+1; reg1=0x000C after N+2; done pulses exactly one cycle at N+2; cmd_ready high after N+3.
- Collision: ra=rb=4, wb=11, A_res=0xAAAA, B_res=0x5555 → reg4=0x5555.
- Flag chaining:
  - First command: ALU model returns ZNC=001.
  - Second command: alu_ZNC=001 during its EXEC.
  - With wb=00, registers are unchanged but flags update.
- Handshake/load gating:
  - cmd_valid held high while busy → no second accept until IDLE.
  - ld_en during EXEC → register unchanged.
  - ld_en and accept in the same cycle, loading ra=0x00FF → alu_A=0x00FF.
- Reset mid-op: assert rst during EXEC → no regfile or flag write, done=0, and state is IDLE the cycle after rst deasserts.
